// File: rtl/imem_loader_pkg.sv
// imem_loader shared definitions: sync byte, FSM state encodings,
// word and counter widths.
package imem_loader_pkg;

    localparam int WORD_WIDTH    = 32;
    localparam int LDR_CNT_WIDTH = 16;

    localparam logic [7:0] LDR_SYNC = 8'hA5;

    typedef enum logic [2:0] {
        LDR_S_SYNC   = 3'd0,
        LDR_S_LEN_HI = 3'd1,
        LDR_S_LEN_LO = 3'd2,
        LDR_S_DATA   = 3'd3,
        LDR_S_CHECK  = 3'd4,
        LDR_S_DONE   = 3'd5,
        LDR_S_ERR    = 3'd6
    } ldr_state_e;

endpackage

// File: rtl/imem_loader.sv
// Framed byte-stream program loader: writes big-endian words into imem
// and holds the CPU until a checksummed frame has fully landed.
// Ports: clk, rst_n (async low), start (re-arm in DONE/ERR),
//   in_valid/in_byte/in_ready (byte stream), mem_we/mem_addr/mem_wdata
//   (imem write port), cpu_hold, done, err, words_loaded.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [WORD_WIDTH-1:0] BASE_ADDR = '0,
    parameter logic [WORD_WIDTH-1:0] ADDR_STEP = WORD_WIDTH'(4),
    parameter int                    DEPTH     = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic [7:0]               in_byte,
    output logic                     in_ready,
    output logic                     mem_we,
    output logic [WORD_WIDTH-1:0]    mem_addr,
    output logic [WORD_WIDTH-1:0]    mem_wdata,
    output logic                     cpu_hold,
    output logic                     done,
    output logic                     err,
    output logic [LDR_CNT_WIDTH-1:0] words_loaded
);

    ldr_state_e state_q, state_d;

    logic [LDR_CNT_WIDTH-1:0] len_q;
    logic [LDR_CNT_WIDTH-1:0] len_n;
    logic [23:0]              asm_q;
    logic [7:0]               chk_q;
    logic [1:0]               byte_cnt;
    logic [WORD_WIDTH-1:0]    addr_nxt;

    logic accept;
    logic start_frame;
    logic data_acc;
    logic word_done;
    logic last_word;

    assign accept      = in_valid && in_ready;
    assign start_frame = (state_q == LDR_S_SYNC) && accept
                         && (in_byte == LDR_SYNC);
    assign data_acc    = (state_q == LDR_S_DATA) && accept;
    assign word_done   = data_acc && (byte_cnt == 2'd3);
    assign last_word   = (words_loaded + 1'b1) == len_q;
    // Full length as seen while the low byte is on the bus.
    assign len_n       = {len_q[15:8], in_byte};

    // FSM state register and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= LDR_S_SYNC;
            in_ready <= 1'b1;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state_q  <= state_d;
            in_ready <= !(state_d inside {LDR_S_DONE, LDR_S_ERR});
            cpu_hold <= (state_d != LDR_S_DONE);
            done     <= (state_d == LDR_S_DONE);
            err      <= (state_d == LDR_S_ERR);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LDR_S_SYNC:
                if (start_frame) state_d = LDR_S_LEN_HI;
            LDR_S_LEN_HI:
                if (accept) state_d = LDR_S_LEN_LO;
            LDR_S_LEN_LO:
                if (accept) begin
                    if (len_n > LDR_CNT_WIDTH'(DEPTH))
                        state_d = LDR_S_ERR;
                    else if (len_n == '0)
                        state_d = LDR_S_CHECK;
                    else
                        state_d = LDR_S_DATA;
                end
            LDR_S_DATA:
                if (word_done && last_word) state_d = LDR_S_CHECK;
            LDR_S_CHECK:
                if (accept)
                    state_d = (in_byte == chk_q) ? LDR_S_DONE : LDR_S_ERR;
            LDR_S_DONE, LDR_S_ERR:
                if (start) state_d = LDR_S_SYNC;
            default:
                state_d = LDR_S_SYNC;
        endcase
    end

    // Length latch, byte assembler, checksum and write strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q     <= '0;
            asm_q     <= '0;
            chk_q     <= '0;
            byte_cnt  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            if (start_frame) begin
                chk_q    <= '0;
                byte_cnt <= '0;
            end
            if ((state_q == LDR_S_LEN_HI) && accept)
                len_q[15:8] <= in_byte;
            if ((state_q == LDR_S_LEN_LO) && accept)
                len_q[7:0] <= in_byte;
            if (data_acc) begin
                asm_q    <= {asm_q[15:0], in_byte};
                chk_q    <= chk_q ^ in_byte;
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (word_done) begin
                mem_we    <= 1'b1;
                mem_wdata <= {asm_q, in_byte};
            end
        end
    end

    // Write address and word counter; address wraps silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr     <= BASE_ADDR;
            addr_nxt     <= BASE_ADDR;
            words_loaded <= '0;
        end else if (start_frame) begin
            addr_nxt     <= BASE_ADDR;
            words_loaded <= '0;
        end else if (word_done) begin
            mem_addr     <= addr_nxt;
            addr_nxt     <= addr_nxt + ADDR_STEP;
            words_loaded <= words_loaded + 1'b1;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued by the
// driver and popped by a write monitor; status is checked after edges.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic [15:0] words_loaded;

    int vectors = 0;
    int miscompares = 0;

    logic [63:0] exp_q[$];

    localparam logic [31:0] W0 = 32'h2001_0005;
    localparam logic [31:0] W1 = 32'h0000_0020;
    // 20^01^00^05^00^00^00^20 = 04
    localparam logic [7:0] GOOD_CK = 8'h04;
    localparam logic [7:0] BAD_CK  = 8'h24;

    imem_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .in_valid     (in_valid),
        .in_byte      (in_byte),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Write monitor: every strobe must match the head of the queue.
    always @(negedge clk) begin
        if (mem_we) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL write: got addr %08h data %08h, none expected",
                         mem_addr, mem_wdata);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== e) begin
                    miscompares++;
                    $display("FAIL write: got %08h/%08h expected %08h/%08h",
                             mem_addr, mem_wdata, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int maxgap);
        chk("in_ready_before_send", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_byte  = b;
        tick();
        in_valid = 1'b0;
        in_byte  = 8'h00;
        repeat ($urandom_range(0, maxgap)) tick();
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        send(w[31:24], maxgap);
        send(w[23:16], maxgap);
        send(w[15:8],  maxgap);
        send(w[7:0],   maxgap);
    endtask

    task automatic frame2(input logic [7:0] ck, input int maxgap);
        exp_q.push_back({32'h0, W0});
        exp_q.push_back({32'h4, W1});
        send(8'hA5, maxgap);
        send(8'h00, maxgap);
        send(8'h02, maxgap);
        send_word(W0, maxgap);
        send_word(W1, maxgap);
        send(ck, maxgap);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic chk_done_ok(input string tag, input logic [15:0] n);
        chk({tag, "_done"}, {31'b0, done}, 32'd1);
        chk({tag, "_err"}, {31'b0, err}, 32'd0);
        chk({tag, "_hold"}, {31'b0, cpu_hold}, 32'd0);
        chk({tag, "_ready"}, {31'b0, in_ready}, 32'd0);
        chk({tag, "_words"}, {16'b0, words_loaded}, {16'b0, n});
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_we"}, {31'b0, mem_we}, 32'd0);
        chk({tag, "_hold"}, {31'b0, cpu_hold}, 32'd1);
        chk({tag, "_ready"}, {31'b0, in_ready}, 32'd1);
        chk({tag, "_done"}, {31'b0, done}, 32'd0);
        chk({tag, "_err"}, {31'b0, err}, 32'd0);
        chk({tag, "_addr"}, mem_addr, 32'h0);
        chk({tag, "_wdata"}, mem_wdata, 32'h0);
        chk({tag, "_words"}, {16'b0, words_loaded}, 32'd0);
    endtask

    initial begin
        repeat (2) tick();
        chk_reset_vals("reset");
        rst_n = 1'b1;
        tick();

        // Normal back-to-back load.
        frame2(GOOD_CK, 0);
        chk_done_ok("normal", 16'd2);
        pulse_start();
        chk("rearm_done", {31'b0, done}, 32'd0);
        chk("rearm_hold", {31'b0, cpu_hold}, 32'd1);
        chk("rearm_ready", {31'b0, in_ready}, 32'd1);

        // Bad checksum: words still written, frame rejected.
        frame2(BAD_CK, 0);
        chk("badck_err", {31'b0, err}, 32'd1);
        chk("badck_done", {31'b0, done}, 32'd0);
        chk("badck_hold", {31'b0, cpu_hold}, 32'd1);
        chk("badck_ready", {31'b0, in_ready}, 32'd0);
        // Start is ignored until the next edge; idle cycle stays in ERR.
        tick();
        chk("err_sticky", {31'b0, err}, 32'd1);
        pulse_start();
        chk("badck_clr_err", {31'b0, err}, 32'd0);
        chk("badck_clr_ready", {31'b0, in_ready}, 32'd1);

        // Garbage before sync is discarded.
        send(8'h00, 0);
        send(8'hFF, 0);
        send(8'h5A, 0);
        frame2(GOOD_CK, 0);
        chk_done_ok("garbage", 16'd2);
        pulse_start();

        // Oversize length: 0x0101 > 256.
        send(8'hA5, 0);
        send(8'h01, 0);
        send(8'h01, 0);
        chk("over_err", {31'b0, err}, 32'd1);
        chk("over_ready", {31'b0, in_ready}, 32'd0);
        chk("over_words", {16'b0, words_loaded}, 32'd0);
        repeat (3) tick();
        pulse_start();

        // Empty frame: checksum of nothing is zero.
        send(8'hA5, 0);
        send(8'h00, 0);
        send(8'h00, 0);
        send(8'h00, 0);
        chk_done_ok("empty", 16'd0);
        pulse_start();

        // Throttled stream: same writes as back-to-back.
        frame2(GOOD_CK, 3);
        chk_done_ok("throttle", 16'd2);
        pulse_start();

        // Start pulse mid-frame is ignored.
        exp_q.push_back({32'h0, W0});
        send(8'hA5, 2);
        pulse_start();
        send(8'h00, 2);
        send(8'h02, 2);
        send_word(W0, 2);
        send(W1[31:24], 2);
        send(W1[23:16], 2);
        chk("midframe_words", {16'b0, words_loaded}, 32'd1);
        chk("midframe_hold", {31'b0, cpu_hold}, 32'd1);

        // Asynchronous reset mid-cycle after 6 data bytes.
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        frame2(GOOD_CK, 1);
        chk_done_ok("post_rst", 16'd2);
        tick();
        chk("pending_writes", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
